pc_branch_unit: RTL and testbench

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

---
 rtl/pc_branch_unit.sv | 108 ++++++++++
 tb/tb_pc_branch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - program counter sequencer with flag-conditioned PC-relative branches
module pc_branch_unit #(
   parameter int              AW       = 10,
   parameter logic [AW-1:0]   RESET_PC = '0
) (
   input  logic          Clock,
   input  logic          Reset_n,
   input  logic          zf,
   input  logic          cf,
   input  logic          flagValid,
   input  logic          step,
   input  logic          brValid,
   input  logic [2:0]    brType,
   input  logic [AW-1:0] brOffset,
   output logic [AW-1:0] pc,
   output logic          zfReg,
   output logic          cfReg,
   output logic          busy,
   output logic          taken,
   output logic          flush
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      RESOLVE = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        state;
   state_t        stateNext;
   logic [2:0]    brTypeReg;
   logic [AW-1:0] brOffsetReg;
   logic [AW-1:0] pcNext;
   logic          accept;
   logic          condMet;

   // Condition is evaluated on the registered flags, so a capture on the accept edge counts.
   always_comb begin
      condMet = 1'b0;
      case (brTypeReg)
         3'b000: condMet = 1'b1;
         3'b001: condMet = zfReg;
         3'b010: condMet = ~zfReg;
         3'b011: condMet = ~zfReg & ~cfReg;
         3'b100: condMet = cfReg;
         3'b101: condMet = ~cfReg;
         3'b110: condMet = cfReg | zfReg;
         3'b111: condMet = 1'b0;
      endcase
   end

   always_comb begin
      stateNext = state;
      pcNext    = pc;
      accept    = 1'b0;
      case (state)
         RUN: begin
            if (brValid) begin
               accept    = 1'b1;
               stateNext = RESOLVE;
            end else if (step) begin
               pcNext = pc + PC_ONE;
            end
         end
         RESOLVE: begin
            // Modular AW-bit addition is identical to adding the sign-extended offset.
            if (condMet) begin
               pcNext    = pc + brOffsetReg;
               stateNext = FLUSH;
            end else begin
               pcNext    = pc + PC_ONE;
               stateNext = RUN;
            end
         end
         FLUSH: stateNext = RUN;
         default: stateNext = RUN;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= RUN;
         pc          <= RESET_PC;
         zfReg       <= 1'b0;
         cfReg       <= 1'b0;
         brTypeReg   <= 3'b000;
         brOffsetReg <= '0;
      end else begin
         state <= stateNext;
         pc    <= pcNext;
         if (flagValid) begin
            zfReg <= zf;
            cfReg <= cf;
         end
         if (accept) begin
            brTypeReg   <= brType;
            brOffsetReg <= brOffset;
         end
      end
   end

   assign busy  = (state != RUN);
   assign taken = (state == RESOLVE) && condMet;
   assign flush = (state == FLUSH);

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - scoreboard bench for pc_branch_unit against a cycle-level model
module tb_pc_branch_unit;
   localparam int            AW       = 10;
   localparam int            MASK     = (1 << AW) - 1;
   localparam logic [AW-1:0] RESET_PC = '0;

   logic          Clock = 1'b0;
   logic          Reset_n = 1'b0;
   logic          zf = 1'b0, cf = 1'b0, flagValid = 1'b0, step = 1'b0, brValid = 1'b0;
   logic [2:0]    brType = 3'd0;
   logic [AW-1:0] brOffset = '0;
   logic [AW-1:0] pc;
   logic          zfReg, cfReg, busy, taken, flush;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic          zf;
      logic          cf;
      logic          busy;
      logic          taken;
      logic          flush;
   } snap_t;

   snap_t expQ[$];
   int    tests = 0;
   int    fails = 0;

   // model: phase 0 idle, 1 branch pending resolution, 2 flushing
   int mPc, mPhase, mType, mOff;
   bit mZf, mCf;

   pc_branch_unit #(.AW(AW), .RESET_PC(RESET_PC)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .zf(zf), .cf(cf), .flagValid(flagValid),
      .step(step), .brValid(brValid), .brType(brType), .brOffset(brOffset),
      .pc(pc), .zfReg(zfReg), .cfReg(cfReg), .busy(busy), .taken(taken), .flush(flush)
   );

   always #5 Clock = ~Clock;

   function automatic bit cond(int t, bit z, bit c);
      case (t)
         0: return 1'b1;
         1: return z;
         2: return !z;
         3: return !z && !c;
         4: return c;
         5: return !c;
         6: return c || z;
         default: return 1'b0;
      endcase
   endfunction

   function automatic snap_t expected();
      snap_t s;
      s.pc    = mPc[AW-1:0];
      s.zf    = mZf;
      s.cf    = mCf;
      s.busy  = (mPhase != 0);
      s.taken = (mPhase == 1) && cond(mType, mZf, mCf);
      s.flush = (mPhase == 2);
      return s;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mPc = RESET_PC; mPhase = 0; mType = 0; mOff = 0; mZf = 0; mCf = 0;
   endtask

   task automatic cyc(input bit fv, input bit z, input bit c, input bit st, input bit bv,
                      input int t, input int off);
      int o;
      @(negedge Clock);
      Reset_n = 1'b1; flagValid = fv; zf = z; cf = c; step = st; brValid = bv;
      brType = t[2:0]; brOffset = off[AW-1:0];
      case (mPhase)
         0: begin
            if (bv) begin mType = t; mOff = off & MASK; mPhase = 1; end
            else if (st) mPc = (mPc + 1) & MASK;
         end
         1: begin
            if (cond(mType, mZf, mCf)) begin
               o = (mOff >= (1 << (AW - 1))) ? mOff - (1 << AW) : mOff;
               mPc = (mPc + o) & MASK;
               mPhase = 2;
            end else begin
               mPc = (mPc + 1) & MASK;
               mPhase = 0;
            end
         end
         default: mPhase = 0;
      endcase
      if (fv) begin mZf = z; mCf = c; end
      expQ.push_back(expected());
   endtask

   task automatic doReset(input int n);
      @(negedge Clock);
      Reset_n = 1'b0; flagValid = 0; step = 0; brValid = 0;
      modelReset();
      expQ.push_back(expected());
      #1;
      chk("async_rst_pc", pc, RESET_PC);
      chk("async_rst_taken", taken, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_zf", zfReg, 0);
      for (int k = 1; k < n; k++) begin
         @(negedge Clock);
         expQ.push_back(expected());
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic settle();
      @(posedge Clock);
      #1;
   endtask

   // monitor: compares the DUT against each expected snapshot, one per clock edge
   initial begin
      snap_t e;
      forever begin
         @(posedge Clock);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("sb_pc", pc, e.pc);
            chk("sb_zfReg", zfReg, e.zf);
            chk("sb_cfReg", cfReg, e.cf);
            chk("sb_busy", busy, e.busy);
            chk("sb_taken", taken, e.taken);
            chk("sb_flush", flush, e.flush);
            if (taken && flush) chk("taken_and_flush", 1, 0);
         end
      end
   end

   initial begin
      bit bv, st;
      modelReset();
      doReset(2);

      repeat (5) cyc(0, 0, 0, 1, 0, 0, 0);
      settle(); chk("five_steps_pc", pc, 5);

      cyc(1, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 1, 16);
      settle(); chk("je_busy", busy, 1); chk("je_taken", taken, 1); chk("je_pc_held", pc, 5);
      idle(1);
      settle(); chk("je_pc", pc, 21); chk("je_flush", flush, 1); chk("je_taken_off", taken, 0);
      idle(1);
      settle(); chk("je_busy_end", busy, 0);

      doReset(1);
      repeat (10) cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 3, 1024 - 3);
      settle(); chk("ja_taken", taken, 0);
      idle(1);
      settle(); chk("ja_pc", pc, 11); chk("ja_flush", flush, 0); chk("ja_busy", busy, 0);

      doReset(1);
      repeat (20) cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 1, 0, 1024 - 25);
      idle(2);
      settle(); chk("jmp_wrap_pc", pc, 1019);

      doReset(1);
      cyc(0, 0, 0, 0, 1, 0, 1023);
      idle(2);
      settle(); chk("pc_max", pc, 1023);
      cyc(0, 0, 0, 1, 0, 0, 0);
      settle(); chk("pc_wrap_zero", pc, 0);

      doReset(1);
      repeat (3) cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 7);
      cyc(0, 0, 0, 1, 1, 0, 100);
      cyc(0, 0, 0, 1, 1, 2, 200);
      settle(); chk("busy_ignore_pc", pc, 10);
      cyc(0, 0, 0, 1, 0, 0, 0);
      settle(); chk("after_busy_step", pc, 11);

      doReset(1);
      cyc(1, 1, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 6, 0);
      idle(1);
      settle(); chk("zero_off_pc", pc, 0); chk("zero_off_flush", flush, 1);

      repeat (4) cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 0, 30);
      doReset(1);
      idle(3);
      settle(); chk("abort_pc", pc, 0); chk("abort_taken", taken, 0);

      repeat (3000) begin
         if ($urandom_range(0, 149) == 0) begin
            doReset($urandom_range(1, 2));
         end else begin
            bv = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 1) == 1);
            cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), st, bv,
                $urandom_range(0, 7), $urandom_range(0, MASK));
         end
      end

      repeat (3) @(negedge Clock);
      chk("queue_drain", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
